imem_server: RTL and testbench

Instruction-memory responder for the RV32I core: serves word-aligned 32-bit instruction fetches over a valid/ready request/response handshake, with a programmable number of wait states to model slower program storage. It also accepts program words through a load port so a test or boot path can fill memory while the core is held off. It sits between the core's fetch stage and program storage, replacing the zero-latency combinational instruction ROM once fetch becomes stall-aware.

---
 rtl/imem_server.sv | 95 +++++++++
 tb/tb_imem_server.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/imem_server.sv
// imem_server: instruction-fetch responder with programmable wait states and a load port for filling memory.
// One request outstanding at a time; memory is read on the edge that enters RESP.
module imem_server #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic        rsp_err,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY == 0 ? 0 : LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_rsp_instr;
    logic        r_rsp_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic [31:0] w_rd_addr;
    logic        w_err;
    logic [31:0] w_word;
    logic        w_load_ok;

    // With zero latency the response is read straight from the incoming address.
    assign w_rd_addr = (r_state == IDLE) ? req_addr : r_addr;
    assign w_err     = (w_rd_addr[1:0] != 2'b00) || (w_rd_addr[31:AW+2] != '0);
    assign w_word    = w_err ? NOP_INSTR : r_mem[w_rd_addr[AW+1:2]];
    assign w_load_ok = (load_addr[1:0] == 2'b00) && (load_addr[31:AW+2] == '0);

    assign req_ready = (r_state == IDLE) && !load_en;
    assign rsp_valid = (r_state == RESP);
    assign busy      = (r_state != IDLE);
    assign rsp_instr = r_rsp_instr;
    assign rsp_err   = r_rsp_err;

    always_ff @(posedge clk) begin
        if (load_en && w_load_ok)
            r_mem[load_addr[AW+1:2]] <= load_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_addr      <= 32'd0;
            r_rsp_instr <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        r_addr <= req_addr;
                        if (LATENCY == 0) begin
                            r_state     <= RESP;
                            r_rsp_instr <= w_word;
                            r_rsp_err   <= w_err;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= RESP;
                        r_rsp_instr <= w_word;
                        r_rsp_err   <= w_err;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_server.sv
// tb_imem_server: directed test of imem_server with LATENCY=2 (dut) and LATENCY=0 (dut0) sharing clock, reset and load port.
module tb_imem_server;
    logic        clk = 1'b0;
    logic        reset;
    logic        load_en;
    logic [31:0] load_addr, load_data;
    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0] req_addr, rsp_instr;
    logic        req_valid0, req_ready0, rsp_valid0, rsp_ready0, rsp_err0, busy0;
    logic [31:0] req_addr0, rsp_instr0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_server #(.DEPTH_WORDS(256), .LATENCY(2), .NOP_INSTR(32'h0000_0013)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr), .rsp_err(rsp_err),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .busy(busy));

    imem_server #(.DEPTH_WORDS(256), .LATENCY(0), .NOP_INSTR(32'h0000_0013)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0), .req_addr(req_addr0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_instr(rsp_instr0), .rsp_err(rsp_err0),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .busy(busy0));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        step();
        load_en = 1'b0;
    endtask

    // Full LATENCY=2 fetch with rsp_ready high: accept, two wait edges, consume.
    task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] exp_i, input logic exp_e);
        req_valid = 1'b1; req_addr = a;
        step();
        req_valid = 1'b0;
        step();
        step();
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_instr"}, rsp_instr, exp_i);
        chk({tag, "_err"}, 32'(rsp_err), 32'(exp_e));
        step();
        chk({tag, "_done"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
        req_valid0 = 1'b0; req_addr0 = '0; rsp_ready0 = 1'b1;
        step();
        step();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_instr", rsp_instr, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        load(32'h0, 32'h0050_0093);
        load(32'h4, 32'h0030_0113);

        // Load then fetch 0x4
        req_valid = 1'b1; req_addr = 32'h4;
        step();
        req_valid = 1'b0;
        chk("f4_w1_valid", 32'(rsp_valid), 32'd0);
        chk("f4_w1_busy", 32'(busy), 32'd1);
        chk("f4_w1_ready", 32'(req_ready), 32'd0);
        step();
        chk("f4_w2_valid", 32'(rsp_valid), 32'd0);
        step();
        chk("f4_valid", 32'(rsp_valid), 32'd1);
        chk("f4_instr", rsp_instr, 32'h0030_0113);
        chk("f4_err", 32'(rsp_err), 32'd0);
        step();
        chk("f4_done_valid", 32'(rsp_valid), 32'd0);
        chk("f4_done_ready", 32'(req_ready), 32'd1);

        // Backpressure on fetch 0x0; request inputs change while busy
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h0;
        step();
        req_addr = 32'h4;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_instr", rsp_instr, 32'h0050_0093);
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        chk("bp_done_valid", 32'(rsp_valid), 32'd0);
        chk("bp_done_ready", 32'(req_ready), 32'd1);

        // Error responses
        fetch("mis", 32'h2, 32'h0000_0013, 1'b1);
        fetch("oor", 32'h400, 32'h0000_0013, 1'b1);

        // Load/request collision in IDLE
        load_en = 1'b1; load_addr = 32'h8; load_data = 32'h0070_0193;
        req_valid = 1'b1; req_addr = 32'h8;
        #1;
        chk("col_ready", 32'(req_ready), 32'd0);
        step();
        load_en = 1'b0;
        #1;
        chk("col_busy_before", 32'(busy), 32'd0);
        chk("col_ready_next", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        chk("col_busy_after", 32'(busy), 32'd1);
        step();
        step();
        chk("col_valid", 32'(rsp_valid), 32'd1);
        chk("col_instr", rsp_instr, 32'h0070_0193);
        step();

        // Write to the same word during WAIT is seen by the response
        req_valid = 1'b1; req_addr = 32'h8;
        step();
        req_valid = 1'b0;
        load_en = 1'b1; load_addr = 32'h8; load_data = 32'h0090_0213;
        step();
        load_en = 1'b0;
        step();
        chk("wr_wait_valid", 32'(rsp_valid), 32'd1);
        chk("wr_wait_instr", rsp_instr, 32'h0090_0213);
        step();

        // LATENCY=0: one response every 2 cycles, in order
        req_valid0 = 1'b1; req_addr0 = 32'h0;
        step();
        req_addr0 = 32'h4;
        chk("l0_a_valid", 32'(rsp_valid0), 32'd1);
        chk("l0_a_instr", rsp_instr0, 32'h0050_0093);
        chk("l0_a_ready", 32'(req_ready0), 32'd0);
        step();
        chk("l0_a_gap", 32'(rsp_valid0), 32'd0);
        chk("l0_a_idle", 32'(req_ready0), 32'd1);
        step();
        req_addr0 = 32'h8;
        chk("l0_b_valid", 32'(rsp_valid0), 32'd1);
        chk("l0_b_instr", rsp_instr0, 32'h0030_0113);
        step();
        chk("l0_b_gap", 32'(rsp_valid0), 32'd0);
        step();
        req_valid0 = 1'b0;
        chk("l0_c_valid", 32'(rsp_valid0), 32'd1);
        chk("l0_c_instr", rsp_instr0, 32'h0090_0213);
        chk("l0_c_err", 32'(rsp_err0), 32'd0);
        step();
        chk("l0_c_done", 32'(rsp_valid0), 32'd0);

        // Out-of-range load is dropped (would alias word 0 otherwise)
        load(32'h400, 32'hDEAD_BEEF);
        load(32'h5, 32'hDEAD_BEEF);

        // Reset during WAIT aborts the request
        req_valid = 1'b1; req_addr = 32'h0;
        step();
        req_valid = 1'b0;
        chk("rw_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("rw_valid", 32'(rsp_valid), 32'd0);
        chk("rw_ready", 32'(req_ready), 32'd1);
        chk("rw_busy_after", 32'(busy), 32'd0);
        step();
        step();
        chk("rw_no_stale", 32'(rsp_valid), 32'd0);
        fetch("refetch0", 32'h0, 32'h0050_0093, 1'b0);
        fetch("refetch4", 32'h4, 32'h0030_0113, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
